// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths, port
// indices, alignment helper and the response-buffer state encoding.
package imem_arbiter_pkg;

    localparam int DEF_AW     = 32;
    localparam int DEF_DW     = 32;
    localparam int PORT_FETCH = 0;
    localparam int PORT_DBG   = 1;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    function automatic logic addr_aligned(input logic [1:0] lsb);
        return (lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/imem_resp_buf.sv
// One-entry valid/ready response holding register with a flush that empties
// it at the next edge regardless of load or consume.
module imem_resp_buf
    import imem_arbiter_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          load_err_i,
    input  logic          flush_i,
    input  logic          resp_ready_i,
    output logic          resp_valid_o,
    output logic [DW-1:0] resp_data_o,
    output logic          resp_err_o,
    output logic          accept_o
);

    buf_state_e    state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        err_d    = err_q;
        // Space is free if empty or the held word leaves this cycle.
        accept_o = (state_q == BUF_EMPTY) || resp_ready_i;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else if (load_i) begin
            state_d = BUF_FULL;
            data_d  = load_data_i;
            err_d   = load_err_i;
        end else if (state_q == BUF_FULL && resp_ready_i) begin
            state_d = BUF_EMPTY;
        end
    end

    assign resp_valid_o = (state_q == BUF_FULL);
    assign resp_data_o  = data_q;
    assign resp_err_o   = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the combinational-read instruction memory: fetch (port 0)
// and debug (port 1), round-robin on conflict, misalignment trapping, fetch flush.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int FETCH_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req_valid,
    output logic          f_req_ready,
    input  logic [AW-1:0] f_req_addr,
    input  logic          f_flush,
    output logic          f_resp_valid,
    input  logic          f_resp_ready,
    output logic [DW-1:0] f_resp_data,
    output logic          f_resp_err,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic [AW-1:0] d_req_addr,
    output logic          d_resp_valid,
    input  logic          d_resp_ready,
    output logic [DW-1:0] d_resp_data,
    output logic          d_resp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    input  logic [DW-1:0] mem_instr
);

    logic rr_q, rr_d;
    logic f_accept, d_accept;
    logic f_elig, d_elig, conflict;
    logic grant_f, grant_d;
    logic f_aligned, d_aligned;
    logic [DW-1:0] f_load_data, d_load_data;

    assign f_aligned = addr_aligned(f_req_addr[1:0]);
    assign d_aligned = addr_aligned(d_req_addr[1:0]);

    // A flush masks the fetch port so the debug port may take the memory.
    assign f_elig   = f_req_valid && f_accept && !f_flush;
    assign d_elig   = d_req_valid && d_accept;
    assign conflict = f_elig && d_elig;

    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        rr_d    = rr_q;
        if (conflict) begin
            if (FETCH_PRIO != 0 || rr_q == 1'(PORT_FETCH)) grant_f = 1'b1;
            else                                            grant_d = 1'b1;
            rr_d = grant_f ? 1'(PORT_DBG) : 1'(PORT_FETCH);
        end else begin
            grant_f = f_elig;
            grant_d = d_elig;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'(PORT_FETCH);
        else        rr_q <= rr_d;
    end

    always_comb begin
        mem_addr = '0;
        mem_re   = 1'b0;
        if (grant_f) begin
            mem_addr = f_req_addr;
            mem_re   = f_aligned;
        end else if (grant_d) begin
            mem_addr = d_req_addr;
            mem_re   = d_aligned;
        end
    end

    assign f_req_ready = grant_f;
    assign d_req_ready = grant_d;
    assign f_load_data = f_aligned ? mem_instr : '0;
    assign d_load_data = d_aligned ? mem_instr : '0;

    imem_resp_buf #(.DW(DW)) u_fetch_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (grant_f),
        .load_data_i  (f_load_data),
        .load_err_i   (!f_aligned),
        .flush_i      (f_flush),
        .resp_ready_i (f_resp_ready),
        .resp_valid_o (f_resp_valid),
        .resp_data_o  (f_resp_data),
        .resp_err_o   (f_resp_err),
        .accept_o     (f_accept)
    );

    imem_resp_buf #(.DW(DW)) u_dbg_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (grant_d),
        .load_data_i  (d_load_data),
        .load_err_i   (!d_aligned),
        .flush_i      (1'b0),
        .resp_ready_i (d_resp_ready),
        .resp_valid_o (d_resp_valid),
        .resp_data_o  (d_resp_data),
        .resp_err_o   (d_resp_err),
        .accept_o     (d_accept)
    );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a per-port response scoreboard and a
// behavioural combinational instruction memory.
module tb_imem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req_valid, f_req_ready, f_flush;
    logic [AW-1:0] f_req_addr;
    logic          f_resp_valid, f_resp_ready, f_resp_err;
    logic [DW-1:0] f_resp_data;
    logic          d_req_valid, d_req_ready;
    logic [AW-1:0] d_req_addr;
    logic          d_resp_valid, d_resp_ready, d_resp_err;
    logic [DW-1:0] d_resp_data;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [DW-1:0] mem_instr;

    logic [DW-1:0] mem [0:63];
    resp_t fq[$];
    resp_t dq[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_instr = mem[mem_addr[7:2]];

    imem_arbiter #(.AW(AW), .DW(DW), .FETCH_PRIO(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_req_valid  (f_req_valid),
        .f_req_ready  (f_req_ready),
        .f_req_addr   (f_req_addr),
        .f_flush      (f_flush),
        .f_resp_valid (f_resp_valid),
        .f_resp_ready (f_resp_ready),
        .f_resp_data  (f_resp_data),
        .f_resp_err   (f_resp_err),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_resp_valid (d_resp_valid),
        .d_resp_ready (d_resp_ready),
        .d_resp_data  (d_resp_data),
        .d_resp_err   (d_resp_err),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_instr    (mem_instr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic resp_t exp_word(input logic [AW-1:0] a);
        resp_t r;
        if (a[1:0] == 2'b00) begin
            r.data = mem[a[7:2]];
            r.err  = 1'b0;
        end else begin
            r.data = '0;
            r.err  = 1'b1;
        end
        return r;
    endfunction

    task automatic check_bufs();
        chk("f_resp_valid", f_resp_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            chk("f_resp_data", f_resp_data, fq[0].data);
            chk("f_resp_err", f_resp_err, fq[0].err);
        end
        chk("d_resp_valid", d_resp_valid, dq.size() != 0);
        if (dq.size() != 0) begin
            chk("d_resp_data", d_resp_data, dq[0].data);
            chk("d_resp_err", d_resp_err, dq[0].err);
        end
    endtask

    // One clock: check grant outputs mid-cycle, update the scoreboard at the edge,
    // then check the response buffers just after it.
    task automatic step(input logic gf, input logic gd);
        logic [AW-1:0] ea, fa, da;
        logic er, cf, cd, fl;
        @(negedge clk);
        fa = f_req_addr;
        da = d_req_addr;
        chk("f_req_ready", f_req_ready, gf);
        chk("d_req_ready", d_req_ready, gd);
        ea = gf ? fa : (gd ? da : '0);
        er = gf ? (fa[1:0] == 2'b00) : (gd ? (da[1:0] == 2'b00) : 1'b0);
        chk("mem_addr", mem_addr, ea);
        chk("mem_re", mem_re, er);
        cf = f_resp_ready && (fq.size() != 0);
        cd = d_resp_ready && (dq.size() != 0);
        fl = f_flush;
        @(posedge clk);
        if (fl) fq.delete();
        else if (cf) void'(fq.pop_front());
        if (cd) void'(dq.pop_front());
        if (gf) fq.push_back(exp_word(fa));
        if (gd) dq.push_back(exp_word(da));
        #1;
        check_bufs();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
        mem[4] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        f_req_valid = 1'b0; f_req_addr = '0; f_flush = 1'b0; f_resp_ready = 1'b0;
        d_req_valid = 1'b0; d_req_addr = '0; d_resp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_f_valid", f_resp_valid, 1'b0);
        chk("rst_d_valid", d_resp_valid, 1'b0);
        chk("rst_f_data", f_resp_data, 32'h0);
        chk("rst_d_err", d_resp_err, 1'b0);
        rst_n = 1'b1;

        // Fetch only
        f_req_valid = 1'b1; f_req_addr = 32'h10; f_resp_ready = 1'b1;
        step(1'b1, 1'b0);
        f_req_valid = 1'b0;
        step(1'b0, 1'b0);

        // Conflict round-robin: F, D, F, D
        f_req_valid = 1'b1; f_req_addr = 32'h20;
        d_req_valid = 1'b1; d_req_addr = 32'h30; d_resp_ready = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        f_req_addr = 32'h24; d_req_addr = 32'h34;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        step(1'b0, 1'b0);

        // Backpressure on fetch
        f_req_valid = 1'b1; f_req_addr = 32'h40;
        step(1'b1, 1'b0);
        f_resp_ready = 1'b0; f_req_addr = 32'h44;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        f_resp_ready = 1'b1;
        step(1'b1, 1'b0);
        f_req_valid = 1'b0;
        step(1'b0, 1'b0);

        // Misaligned debug read
        d_req_valid = 1'b1; d_req_addr = 32'h6;
        step(1'b0, 1'b1);
        d_req_valid = 1'b0;
        step(1'b0, 1'b0);

        // Flush with pending fetch response, debug takes the memory
        f_req_valid = 1'b1; f_req_addr = 32'h50; f_resp_ready = 1'b0;
        step(1'b1, 1'b0);
        f_flush = 1'b1; f_resp_ready = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h54;
        step(1'b0, 1'b1);
        f_flush = 1'b0; f_req_valid = 1'b0; d_req_valid = 1'b0;
        step(1'b0, 1'b0);

        // Fill both buffers (leaves rr pointing at debug), then async reset
        f_resp_ready = 1'b0; d_resp_ready = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 32'h08;
        d_req_valid = 1'b1; d_req_addr = 32'h0C;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_f_valid", f_resp_valid, 1'b0);
        chk("arst_d_valid", d_resp_valid, 1'b0);
        chk("arst_d_data", d_resp_data, 32'h0);
        fq.delete();
        dq.delete();
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        f_req_valid = 1'b1; d_req_valid = 1'b1;
        f_resp_ready = 1'b1; d_resp_ready = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
